cache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate cache controller that drives the 8-entry line data array.

---
 rtl/cache_ctrl_if.sv | 50 +++++
 rtl/cache_ctrl.sv | 157 +++++++++++++++
 tb/tb_cache_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if
// Groups the three buses of the cache controller into one bundle:
//   CPU port   : mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable -> mem_rdata, mem_resp
//   pmem port  : pmem_read, pmem_write, pmem_address, pmem_wdata <- pmem_rdata, pmem_resp
//   data array : data_index, data_write, data_in <- data_out (combinational read)
// Modports:
//   slave  - the cache controller's view
//   master - the environment's view (CPU, physical memory and line data array)
interface cache_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 256,
    parameter int WORD_W = 16,
    parameter int IDX_W  = 3
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_wdata;
    logic [1:0]        mem_byte_enable;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic [IDX_W-1:0]  data_index;
    logic              data_write;
    logic [LINE_W-1:0] data_in;
    logic [LINE_W-1:0] data_out;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  pmem_rdata, pmem_resp, data_out,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        output data_index, data_write, data_in
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output pmem_rdata, pmem_resp, data_out,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  data_index, data_write, data_in
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl
// Direct-mapped, write-back, write-allocate cache controller for an 8-line cache.
// Holds tag/valid/dirty per set; line data lives in an external array driven
// through the data_* signals. Sequences CPU hits, dirty-line writeback and line fill.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - cache_ctrl_if.slave: CPU port, pmem port and data array port
module cache_ctrl #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 256,
    parameter int WORD_W = 16,
    parameter int IDX_W  = 3
) (
    input logic         clk,
    input logic         rst_n,
    cache_ctrl_if.slave bus
);
    localparam int OFF_W = 5;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int SEL_W = OFF_W - 1;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    state_t            state;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q [SETS];

    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              req_write;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [SEL_W-1:0]  req_sel;
    logic              hit;
    logic              unused_addr_lsb;

    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] merged_word;
    logic [LINE_W-1:0] merged_line;

    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_sel = req_addr[OFF_W-1:1];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Byte address bit 0 plays no part in word selection.
    assign unused_addr_lsb = req_addr[0];

    // Selected word of the current line and its byte-merged replacement for write hits.
    always_comb begin
        cur_word    = bus.data_out[int'(req_sel)*WORD_W +: WORD_W];
        merged_word = cur_word;
        if (req_be[0]) merged_word[7:0] = req_wdata[7:0];
        if (req_be[1]) merged_word[WORD_W-1:8] = req_wdata[WORD_W-1:8];
        merged_line = bus.data_out;
        merged_line[int'(req_sel)*WORD_W +: WORD_W] = merged_word;
    end

    // Outputs decode from the registered state and latched request only, so an
    // asynchronous reset forces every output to 0 immediately. The array index is
    // always the latched index so data_out tracks the set under service.
    always_comb begin
        bus.mem_rdata    = '0;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.data_index   = req_idx;
        bus.data_write   = 1'b0;
        bus.data_in      = '0;
        case (state)
            CHECK: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    if (req_write) begin
                        bus.data_write = 1'b1;
                        bus.data_in    = merged_line;
                    end else begin
                        bus.mem_rdata = cur_word;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                bus.pmem_wdata   = bus.data_out;
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (bus.pmem_resp) begin
                    bus.data_write = 1'b1;
                    bus.data_in    = bus.pmem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Controller FSM plus per-set bookkeeping. A fill returns to CHECK, which then
    // completes the access as a guaranteed hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
            for (int i = 0; i < SETS; i++) tag_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        req_addr  <= bus.mem_address;
                        req_wdata <= bus.mem_wdata;
                        req_be    <= bus.mem_byte_enable;
                        req_write <= bus.mem_write;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        if (req_write) dirty_q[req_idx] <= 1'b1;
                        state <= IDLE;
                    end else if (dirty_q[req_idx]) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[req_idx] <= 1'b0;
                        state            <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        tag_q[req_idx]   <= req_tag;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        state            <= CHECK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
// Self-checking bench for cache_ctrl. Plays the CPU, physical memory and the
// line data array, and predicts every access from a set-level cache model.
module tb_cache_ctrl;
    logic clk;
    logic rst_n;

    cache_ctrl_if bus ();

    cache_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Line data array: combinational read, write on the clock edge.
    logic [255:0] dataArray [8];
    assign bus.data_out = dataArray[bus.data_index];
    always @(posedge clk) if (bus.data_write) dataArray[bus.data_index] <= bus.data_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checksTotal;
    int checksPassed;

    // Reference model: what each set holds, and what physical memory holds.
    logic         mValid [8];
    logic         mDirty [8];
    logic [7:0]   mTag   [8];
    logic [255:0] mLine  [8];
    logic [255:0] pmemStore [int];

    // Untouched memory: word k of line A reads (A ^ 0x0040) + k.
    function automatic logic [255:0] pmemLine(input logic [15:0] a);
        logic [255:0] l;
        if (pmemStore.exists(int'(a))) return pmemStore[int'(a)];
        for (int k = 0; k < 16; k++) l[k*16 +: 16] = (a ^ 16'h0040) + 16'(k);
        return l;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
    endfunction

    // Runs one CPU access from an IDLE cycle (posedge+1) to the IDLE cycle after mem_resp,
    // answering pmem after the given extra wait cycles, and checks it against the model.
    task automatic applyStimulus(input logic isWrite, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be,
                                 input int wbDelay, input int fillDelay, input string name,
                                 output logic [15:0] gotRdata, output int gotLat,
                                 output logic [255:0] gotWbLine);
        int idx, sel, expLat, wbCyc, fillCyc;
        logic [7:0] tagv;
        logic expHit, expWb, wbSeen, fillSeen, done, stableOk, bothHigh;
        logic [15:0] expWbAddr, expFillAddr, expRdata, w;
        logic [255:0] expWbLine, fillLine;

        idx  = int'(addr[7:5]);
        sel  = int'(addr[4:1]);
        tagv = addr[15:8];
        expHit      = mValid[idx] && (mTag[idx] == tagv);
        expWb       = !expHit && mValid[idx] && mDirty[idx];
        expWbAddr   = {mTag[idx], addr[7:5], 5'b0};
        expWbLine   = mLine[idx];
        expFillAddr = {tagv, addr[7:5], 5'b0};
        expLat      = expHit ? 1 : (expWb ? 4 + wbDelay + fillDelay : 3 + fillDelay);
        if (expWb) pmemStore[int'(expWbAddr)] = expWbLine;
        fillLine = pmemLine(expFillAddr);
        if (!expHit) begin
            mLine[idx]  = fillLine;
            mValid[idx] = 1'b1;
            mTag[idx]   = tagv;
            mDirty[idx] = 1'b0;
        end
        expRdata = 16'h0000;
        if (isWrite) begin
            w = mLine[idx][sel*16 +: 16];
            if (be[0]) w[7:0]  = wdata[7:0];
            if (be[1]) w[15:8] = wdata[15:8];
            mLine[idx][sel*16 +: 16] = w;
            mDirty[idx] = 1'b1;
        end else begin
            expRdata = mLine[idx][sel*16 +: 16];
        end

        bus.mem_read        = !isWrite;
        bus.mem_write       = isWrite;
        bus.mem_address     = addr;
        bus.mem_wdata       = wdata;
        bus.mem_byte_enable = be;

        done = 0; wbSeen = 0; fillSeen = 0; stableOk = 1; bothHigh = 0;
        wbCyc = 0; fillCyc = 0; gotLat = -1; gotRdata = '0; gotWbLine = '0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(posedge clk); #1;
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) bothHigh = 1;
            if (bus.pmem_write) begin
                if (!wbSeen) begin
                    wbSeen    = 1;
                    gotWbLine = bus.pmem_wdata;
                    checksTotal++;
                    if (bus.pmem_address !== expWbAddr)
                        $display("[TB] FAIL %s wb_addr: got %h, expected %h", name, bus.pmem_address, expWbAddr);
                    else checksPassed++;
                    checksTotal++;
                    if (bus.pmem_wdata !== expWbLine)
                        $display("[TB] FAIL %s wb_data: got %h, expected %h", name, bus.pmem_wdata, expWbLine);
                    else checksPassed++;
                end else if (bus.pmem_address !== expWbAddr || bus.pmem_wdata !== expWbLine) begin
                    stableOk = 0;
                end
                wbCyc++;
                if (wbCyc > wbDelay) bus.pmem_resp = 1'b1;
            end else if (bus.pmem_read) begin
                if (!fillSeen) begin
                    fillSeen = 1;
                    checksTotal++;
                    if (bus.pmem_address !== expFillAddr)
                        $display("[TB] FAIL %s fill_addr: got %h, expected %h", name, bus.pmem_address, expFillAddr);
                    else checksPassed++;
                end else if (bus.pmem_address !== expFillAddr) begin
                    stableOk = 0;
                end
                fillCyc++;
                if (fillCyc > fillDelay) begin
                    bus.pmem_rdata = fillLine;
                    bus.pmem_resp  = 1'b1;
                end
            end
            #1;
            if (bus.mem_resp) begin
                done     = 1;
                gotLat   = c;
                gotRdata = bus.mem_rdata;
            end
        end
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;

        checksTotal++;
        if (gotLat !== expLat)
            $display("[TB] FAIL %s latency: got %0d, expected %0d", name, gotLat, expLat);
        else checksPassed++;
        checksTotal++;
        if (gotRdata !== expRdata)
            $display("[TB] FAIL %s rdata: got %h, expected %h", name, gotRdata, expRdata);
        else checksPassed++;
        checksTotal++;
        if ({wbSeen, fillSeen, stableOk, bothHigh} !== {expWb, !expHit, 1'b1, 1'b0})
            $display("[TB] FAIL %s pmem_seq: got wb=%b fill=%b stable=%b both=%b, expected wb=%b fill=%b stable=1 both=0",
                     name, wbSeen, fillSeen, stableOk, bothHigh, expWb, !expHit);
        else checksPassed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        #1;
        checksTotal++;
        if ({bus.mem_resp, bus.mem_rdata, bus.pmem_read, bus.pmem_write, bus.data_write, bus.data_index} !== '0)
            $display("[TB] FAIL reset_ctrl: got resp=%b rdata=%h pr=%b pw=%b dw=%b di=%0d, expected all 0",
                     bus.mem_resp, bus.mem_rdata, bus.pmem_read, bus.pmem_write, bus.data_write, bus.data_index);
        else checksPassed++;
        checksTotal++;
        if ({bus.pmem_address, bus.pmem_wdata, bus.data_in} !== '0)
            $display("[TB] FAIL reset_buses: got addr=%h wdata=%h din=%h, expected 0",
                     bus.pmem_address, bus.pmem_wdata, bus.data_in);
        else checksPassed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_read();
        logic [15:0] r; int lat; logic [255:0] wl;
        applyStimulus(1'b0, 16'h0040, 16'h0, 2'b00, 0, 2, "fill_read", r, lat, wl);
        checksTotal++;
        if (r !== 16'h0000) $display("[TB] FAIL fill_read_word0: got %h, expected 0000", r);
        else checksPassed++;
    endtask

    task automatic test_read_hit();
        logic [15:0] r; int lat; logic [255:0] wl;
        applyStimulus(1'b0, 16'h0046, 16'h0, 2'b00, 0, 0, "read_hit", r, lat, wl);
        checksTotal++;
        if (r !== 16'h0003 || lat !== 1)
            $display("[TB] FAIL read_hit_word3: got %h lat %0d, expected 0003 lat 1", r, lat);
        else checksPassed++;
    endtask

    task automatic test_writeback();
        logic [15:0] r; int lat; logic [255:0] wl;
        applyStimulus(1'b1, 16'h0042, 16'hBEEF, 2'b11, 0, 0, "write_hit", r, lat, wl);
        applyStimulus(1'b0, 16'h0140, 16'h0, 2'b00, 1, 1, "dirty_miss", r, lat, wl);
        checksTotal++;
        if (wl[31:16] !== 16'hBEEF)
            $display("[TB] FAIL wb_word1: got %h, expected beef", wl[31:16]);
        else checksPassed++;
    endtask

    task automatic test_partial_write();
        logic [15:0] r; int lat; logic [255:0] wl;
        applyStimulus(1'b1, 16'h0044, 16'h1234, 2'b01, 0, 0, "byte_write", r, lat, wl);
        applyStimulus(1'b0, 16'h0044, 16'h0, 2'b00, 0, 0, "byte_readback", r, lat, wl);
        checksTotal++;
        if (r !== 16'h0034) $display("[TB] FAIL byte_merge: got %h, expected 0034", r);
        else checksPassed++;
    endtask

    task automatic test_reset_mid_fill();
        int fillCyc;
        logic stable;
        logic [15:0] r; int lat; logic [255:0] wl;
        fillCyc = 0;
        stable  = 1;
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0060;
        for (int c = 1; c <= 20 && fillCyc < 5; c++) begin
            @(posedge clk); #1;
            if (bus.pmem_read) begin
                fillCyc++;
                if (bus.pmem_address !== 16'h0060) stable = 0;
            end
        end
        checksTotal++;
        if (fillCyc !== 5 || !stable)
            $display("[TB] FAIL fill_hold: got %0d stable cycles (stable=%b), expected 5 (stable=1)", fillCyc, stable);
        else checksPassed++;
        rst_n = 1'b0;
        #1;
        checksTotal++;
        if ({bus.pmem_read, bus.pmem_address} !== '0)
            $display("[TB] FAIL reset_mid_fill: got pmem_read=%b addr=%h, expected 0 0000", bus.pmem_read, bus.pmem_address);
        else checksPassed++;
        bus.mem_read = 1'b0;
        modelReset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.pmem_rdata = {8{32'hA5A5_5A5A}};
        bus.pmem_resp  = 1'b1;
        #1;
        checksTotal++;
        if ({bus.data_write, bus.pmem_read, bus.mem_resp} !== 3'b000)
            $display("[TB] FAIL late_resp: got dw=%b pr=%b resp=%b, expected 000", bus.data_write, bus.pmem_read, bus.mem_resp);
        else checksPassed++;
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        applyStimulus(1'b0, 16'h0060, 16'h0, 2'b00, 0, 0, "reread_after_reset", r, lat, wl);
        checksTotal++;
        if (lat !== 3) $display("[TB] FAIL reread_misses: got latency %0d, expected 3", lat);
        else checksPassed++;
    endtask

    task automatic test_index_wrap();
        logic [15:0] r; int lat; logic [255:0] wl;
        logic [255:0] lineE;
        for (int k = 0; k < 8; k++) lineE[k*32 +: 32] = $urandom;
        pmemStore[int'(16'h00E0)] = lineE;
        pmemStore[int'(16'h0000)] = ~lineE;
        applyStimulus(1'b0, 16'h00E6, 16'h0, 2'b00, 0, 1, "fill_idx7", r, lat, wl);
        applyStimulus(1'b0, 16'h0006, 16'h0, 2'b00, 0, 1, "fill_idx0", r, lat, wl);
        applyStimulus(1'b0, 16'h00E6, 16'h0, 2'b00, 0, 0, "hit_idx7", r, lat, wl);
        checksTotal++;
        if (r !== lineE[63:48] || lat !== 1)
            $display("[TB] FAIL idx7_data: got %h lat %0d, expected %h lat 1", r, lat, lineE[63:48]);
        else checksPassed++;
        applyStimulus(1'b0, 16'h0006, 16'h0, 2'b00, 0, 0, "hit_idx0", r, lat, wl);
        checksTotal++;
        if (r !== ~lineE[63:48] || lat !== 1)
            $display("[TB] FAIL idx0_data: got %h lat %0d, expected %h lat 1", r, lat, ~lineE[63:48]);
        else checksPassed++;
    endtask

    task automatic test_random();
        logic [15:0] r, a; int lat; logic [255:0] wl;
        for (int n = 0; n < 40; n++) begin
            a = {6'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0};
            applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 3), $urandom_range(0, 3), "random", r, lat, wl);
        end
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) dataArray[i][k*32 +: 32] = $urandom;
            mTag[i]  = '0;
            mLine[i] = '0;
        end
        test_reset();
        test_fill_read();
        test_read_hit();
        test_writeback();
        test_partial_write();
        test_reset_mid_fill();
        test_index_wrap();
        test_random();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
